crc_checker: RTL
================

# crc_checker

Serial CRC checker that receives the output side of the team's serial CRC generator. It recomputes the LFSR over the serial data bits while `ACTIVE` is high, then compares the following `CRC_WIDTH` serial CRC bits, LSB first, against its own register. It reports a one-cycle verdict per frame. It sits at the receive end of the serial link and uses the same seed and polynomial as the generator.

## Interface

- `CRC_WIDTH`, 8: LFSR and CRC width.
- `SEED`, 8'hD8: LFSR value at frame start.
- `POLY`, 8'hC4: feedback tap mask (bit i set means tap into stage i); `POLY[CRC_WIDTH-1]` must be 1.
- `CLK`  in  1: single clock, rising edge.
- `RST`  in  1: reset; asynchronous and active-high.
- `ACTIVE`  in  1: data phase qualifier; one data bit per cycle while high.
- `DATA`  in  1: serial data bit, LSB first.
- `CRC_VALID`  in  1: CRC phase qualifier; one CRC bit per cycle while high.
- `CRC_IN`  in  1: serial received CRC bit, LSB first.
- `DONE`  out  1: one-cycle pulse; verdict outputs update on the same cycle.
- `CRC_OK`  out  1: last frame matched; held until next frame start.
- `CRC_ERR`  out  1: last frame mismatched or truncated; held until next frame start.
- `FRAME_ERR`  out  1: last frame's CRC phase was shorter than `CRC_WIDTH` bits; held.
- `ERR_CNT`  out  8: saturating count of frames with `CRC_ERR` (see Configuration).

## Operation

- LFSR step, with R the register and d the input bit:
  - fb = d ^ R[0]
  - R_next = (R >> 1) ^ ({CRC_WIDTH{fb}} & POLY)
- States and transitions:
  - **IDLE**: if `ACTIVE`=1, R <= step(SEED, DATA), clear `CRC_OK`/`CRC_ERR`/`FRAME_ERR` and the mismatch flag, then go to DATA. Otherwise hold.
  - **DATA**: if `ACTIVE`=1, R <= step(R, DATA). If `ACTIVE`=0, go to WAIT. `CRC_VALID` is ignored in DATA.
  - **WAIT**: if `CRC_VALID`=1, take the first CRC bit (compare, shift, cnt=1) and go to CHECK. If `ACTIVE`=1 before any CRC bit arrives, the frame is silently abandoned and handled as an IDLE start (reseed, step). Otherwise hold.
  - **CHECK**: if `CRC_VALID`=1:
    - mismatch |= (`CRC_IN` != R[0])
    - R <= R >> 1 (zero fill)
    - cnt++
    - after the bit that makes cnt == `CRC_WIDTH`, go to REPORT with FRAME_ERR=0.
  - If `CRC_VALID`=0 in CHECK with cnt < `CRC_WIDTH`, go to REPORT with FRAME_ERR=1. `ACTIVE` is ignored in CHECK.
  - **REPORT**: for one cycle, `DONE`=1, `CRC_OK` = !(mismatch | FRAME_ERR), `CRC_ERR` = its complement. Then go to IDLE. `ACTIVE`=1 here is ignored and the frame is lost; a minimum of one idle cycle between frames is required.
- Bit counter: width $clog2(`CRC_WIDTH`+1). It cannot wrap because the exit happens at `CRC_WIDTH`.
- Data phase length is unbounded, minimum 1 bit.

## Timing

- Reset values: state IDLE, R = `SEED`, cnt = 0, and `DONE`, `CRC_OK`, `CRC_ERR`, `FRAME_ERR`, `ERR_CNT` all 0.
- Reset mid-frame aborts immediately. There is no `DONE` and no counter update.
- All inputs are sampled at the rising edge of `CLK`. All outputs are registered.
- `DONE` rises on the clock edge after the edge that sampled the last CRC bit (or the edge that sampled the early `CRC_VALID` drop).
- The verdict is visible the cycle after the final CRC bit is sampled, so latency is 1 cycle.
- Back-to-back with the generator: the generator's `VALID` connects to `CRC_VALID` and its `CRC` to `CRC_IN`. Any gap of cycles between `ACTIVE` falling and `CRC_VALID` rising is tolerated.

## Configuration

- **`CRC_CHK_ERRCNT_EN` defined:**
  - 8-bit `ERR_CNT` increments on each `DONE` with `CRC_ERR`=1.
  - It saturates at 8'hFF and is cleared only by `RST`.
- **Not defined:**
  - `ERR_CNT` is tied to 8'h00 and no counter register is built.
  - The port remains present.

## Test plan

- Good frame: data 0x00 (8 bits, LSB first), then CRC 0x14 (bits 0,0,1,0,1,0,0,0) → `DONE` pulse, `CRC_OK`=1, `CRC_ERR`=0, `FRAME_ERR`=0.
- Corrupt CRC: same data, CRC 0x15 → `CRC_OK`=0, `CRC_ERR`=1, `FRAME_ERR`=0. With the macro defined, `ERR_CNT` goes 0→1.
- Truncated CRC: data 0x00, `CRC_VALID` high for 5 bits (0,0,1,0,1), then low → `DONE` on the next cycle, `CRC_ERR`=1, `FRAME_ERR`=1.
- Gap and abandon: data 0x00, `CRC_VALID` delayed 3 cycles → OK. Separately, `ACTIVE` reasserting in WAIT with new data 0x00 and CRC 0x14 → a single `DONE` with OK.
- Reset mid-CHECK after 3 CRC bits → all outputs 0, no `DONE`. A following good frame (0x00 / 0x14) → `CRC_OK`=1.
- Saturation (macro defined): 256 corrupt frames → `ERR_CNT`=8'hFF and it stays there. Without the macro, `ERR_CNT` stays 0.

Source files
------------

// File: rtl/crc_checker.sv
// ============================================================================
// crc_checker : serial LFSR CRC checker with one-cycle per-frame verdict.
// Optional macro CRC_CHK_ERRCNT_EN builds the saturating error-frame counter.
// Revision 1.0
// ============================================================================
`default_nettype none

module crc_checker #(
  parameter int                   CRC_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] SEED      = 8'hD8,
  parameter logic [CRC_WIDTH-1:0] POLY      = 8'hC4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ACTIVE,
  input  logic       DATA,
  input  logic       CRC_VALID,
  input  logic       CRC_IN,
  output logic       DONE,
  output logic       CRC_OK,
  output logic       CRC_ERR,
  output logic       FRAME_ERR,
  output logic [7:0] ERR_CNT
);

  localparam int            CW       = $clog2(CRC_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CRC_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_WAIT   = 3'd2,
    S_CHECK  = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [CRC_WIDTH-1:0] lfsr, lfsr_n;
  logic [CW-1:0]        cnt, cnt_n, cnt_inc;
  logic                 mismatch, mismatch_n, bit_mm;
  logic                 done_n, ok_n, err_n, frame_err_n;

  function automatic logic [CRC_WIDTH-1:0] step(input logic [CRC_WIDTH-1:0] r, input logic d);
    logic fb;
    fb = d ^ r[0];
    return (r >> 1) ^ ({CRC_WIDTH{fb}} & POLY);
  endfunction

  assign cnt_inc = cnt + 1'b1;
  assign bit_mm  = mismatch | (CRC_IN != lfsr[0]);

  always_comb begin
    state_n     = state;
    lfsr_n      = lfsr;
    cnt_n       = cnt;
    mismatch_n  = mismatch;
    done_n      = 1'b0;
    ok_n        = CRC_OK;
    err_n       = CRC_ERR;
    frame_err_n = FRAME_ERR;

    case (state)
      S_IDLE, S_WAIT: begin
        if (state == S_WAIT && CRC_VALID) begin
          // first CRC bit: cnt was cleared at frame start
          mismatch_n = bit_mm;
          lfsr_n     = lfsr >> 1;
          cnt_n      = cnt_inc;
          if (cnt_inc == CNT_LAST) begin
            state_n     = S_REPORT;
            done_n      = 1'b1;
            frame_err_n = 1'b0;
            ok_n        = !bit_mm;
            err_n       = bit_mm;
          end else begin
            state_n = S_CHECK;
          end
        end else if (ACTIVE) begin
          // frame start (also restarts a frame abandoned while waiting for CRC)
          lfsr_n      = step(SEED, DATA);
          cnt_n       = '0;
          mismatch_n  = 1'b0;
          ok_n        = 1'b0;
          err_n       = 1'b0;
          frame_err_n = 1'b0;
          state_n     = S_DATA;
        end
      end
      S_DATA: begin
        if (ACTIVE) lfsr_n = step(lfsr, DATA);
        else        state_n = S_WAIT;
      end
      S_CHECK: begin
        state_n = S_REPORT;
        done_n  = 1'b1;
        if (CRC_VALID) begin
          mismatch_n = bit_mm;
          lfsr_n     = lfsr >> 1;
          cnt_n      = cnt_inc;
          if (cnt_inc == CNT_LAST) begin
            frame_err_n = 1'b0;
            ok_n        = !bit_mm;
            err_n       = bit_mm;
          end else begin
            state_n = S_CHECK;
            done_n  = 1'b0;
          end
        end else begin
          frame_err_n = 1'b1;
          ok_n        = 1'b0;
          err_n       = 1'b1;
        end
      end
      S_REPORT: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      lfsr      <= SEED;
      cnt       <= '0;
      mismatch  <= 1'b0;
      DONE      <= 1'b0;
      CRC_OK    <= 1'b0;
      CRC_ERR   <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      state     <= state_n;
      lfsr      <= lfsr_n;
      cnt       <= cnt_n;
      mismatch  <= mismatch_n;
      DONE      <= done_n;
      CRC_OK    <= ok_n;
      CRC_ERR   <= err_n;
      FRAME_ERR <= frame_err_n;
    end
  end

`ifdef CRC_CHK_ERRCNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                        err_cnt <= 8'h00;
    else if (done_n && err_n && err_cnt != 8'hFF)   err_cnt <= err_cnt + 8'h01;
  end

  assign ERR_CNT = err_cnt;
`else
  assign ERR_CNT = 8'h00;
`endif

endmodule

`default_nettype wire
